// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// RV32M funct3 operation codes and the sequencer state encoding.
package mdu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq_ctrl_iter_core.sv
// Iteration datapath: 64-bit shift-add multiplier accumulator and
// restoring divider (quotient shares the low accumulator word).
// Operands are unsigned magnitudes; sign handling lives in the FSM.
module mdu_iter_core
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                div_mode,
    input  logic [XLEN-1:0]     a_in,
    input  logic [XLEN-1:0]     b_in,
    output logic [2*XLEN-1:0]   prod,
    output logic [XLEN-1:0]     quot,
    output logic [XLEN-1:0]     remd
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   bop;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   rem_nxt;

    // One iteration step: multiply adds/shifts right, divide shifts left and trial-subtracts
    always_comb begin
        add_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bop} : {(XLEN+1){1'b0}});
        rem_shift = {rem, acc[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, bop});
        acc_nxt   = acc;
        rem_nxt   = rem;
        if (div_mode) begin
            acc_nxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], rem_ge};
            rem_nxt = rem_ge ? XLEN'(rem_shift - {1'b0, bop}) : rem_shift[XLEN-1:0];
        end else begin
            acc_nxt = {add_sum, acc[XLEN-1:1]};
        end
    end

    // Iteration registers: loaded on accept, advanced once per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            rem <= '0;
            bop <= '0;
        end else if (load) begin
            acc <= {{XLEN{1'b0}}, a_in};
            rem <= '0;
            bop <= b_in;
        end else if (step) begin
            acc <= acc_nxt;
            rem <= rem_nxt;
        end
    end

    assign prod = acc;
    assign quot = acc[XLEN-1:0];
    assign remd = rem;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle RV32M sequencer: accepts one op in IDLE, runs ITER
// iteration steps, applies sign correction, then pulses done.
// Divide-by-zero and signed overflow complete directly from IDLE.
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(ITER);

    mdu_state_e        state, state_nxt;
    mdu_op_e           op_in, op_q;
    logic              sign1_q, sign2_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept, load, step;
    logic              sign1_in, sign2_in, special;
    logic [XLEN-1:0]   mag1, mag2, special_res, fix_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, remd, quot_fix, rem_fix;

    function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Decode the incoming request: sign flags, magnitudes and the early-completion cases
    always_comb begin
        op_in       = mdu_op_e'(op);
        sign1_in    = operand1[XLEN-1] & (op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
        sign2_in    = operand2[XLEN-1] & (op_in inside {MDU_MULH, MDU_DIV, MDU_REM});
        mag1        = sign1_in ? (~operand1 + 1'b1) : operand1;
        mag2        = sign2_in ? (~operand2 + 1'b1) : operand2;
        special     = 1'b0;
        special_res = '0;
        if (op[2] && (operand2 == '0)) begin
            special     = 1'b1;
            special_res = op[1] ? operand1 : {XLEN{1'b1}};
        end else if ((op_in inside {MDU_DIV, MDU_REM}) &&
                     (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == {XLEN{1'b1}})) begin
            special     = 1'b1;
            special_res = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end
        accept = (state == ST_IDLE) && start && !flush;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: flush aborts CALC/FIX; DONE always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (flush) state_nxt = ST_IDLE;
                     else if (cnt == CNT_W'(ITER-1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and datapath controls derived from the current state
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        load = accept;
        step = (state == ST_CALC);
    end

    // Latched request context and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MDU_MUL;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            sign1_q <= sign1_in;
            sign2_q <= sign2_in;
            cnt     <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .div_mode (op_q[2]),
        .a_in     (mag1),
        .b_in     (mag2),
        .prod     (prod),
        .quot     (quot),
        .remd     (remd)
    );

    // Sign correction and result word selection for the FIX state
    always_comb begin
        prod_fix = cond_neg(prod, sign1_q ^ sign2_q);
        quot_fix = XLEN'(cond_neg({{XLEN{1'b0}}, quot}, sign1_q ^ sign2_q));
        rem_fix  = XLEN'(cond_neg({{XLEN{1'b0}}, remd}, sign1_q));
        case (op_q)
            MDU_MUL:                          fix_res = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_res = quot_fix;
            default:                          fix_res = rem_fix;
        endcase
    end

    // Result register: loaded by early completion or by a non-flushed FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              result <= '0;
        else if (accept && special)           result <= special_res;
        else if ((state == ST_FIX) && !flush) result <= fix_res;
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed RV32M cases, abort,
// reset and randomized operations against an arithmetic reference model.
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;

    mdu_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics via 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs while busy, check latency/result/done pulse
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int   cyc;
        logic bok;
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        @(posedge clk);
        cyc = 1;
        bok = 1'b1;
        @(negedge clk);
        while (!done && cyc < 60) begin
            if (!busy) bok = 1'b0;
            start    = 1'($urandom_range(0, 1));
            op       = 3'($urandom);
            operand1 = $urandom;
            operand2 = $urandom;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat_model(o, a, b)));
        chk({tag, " result"}, result, exp);
        chk({tag, " busy"}, {31'b0, bok & busy}, 32'd1);
        start = 1'b1; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " idle after done"}, {30'b0, busy, done}, 32'd0);
        start = 1'b0;
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          seen;

        rst = 1'b1; start = 1'b0; op = 3'd0; operand1 = '0; operand2 = '0; flush = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;

        run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, "MULH");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "MULHSU");
        run_op(3'd0, 32'd7, 32'd6, 32'h0000002A, "MUL");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "DIV");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "REM");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "REMU");
        run_op(3'd5, 32'h12345678, 32'd0, 32'hFFFFFFFF, "DIVU by zero");
        run_op(3'd6, 32'h12345678, 32'd0, 32'h12345678, "REM by zero");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV overflow");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "REM overflow");

        // Flush in CALC cycle 10: abort, no done, result held
        @(negedge clk);
        start = 1'b1; op = 3'd3; operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush done", {31'b0, done}, 32'd0);
        chk("flush result", result, last_res);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("flush no late done", 32'(seen), 32'd0);

        // Flush has priority over a simultaneous start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd5; operand1 = 32'd9; operand2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {30'b0, busy, done}, 32'd0);
        chk("flush+start result", result, last_res);

        // Randomized operations with occasional zero / overflow divisors
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, ref_model(ro, ra, rb), "random");
        end

        // Asynchronous reset mid-CALC takes effect before the next clock edge
        @(negedge clk);
        start = 1'b1; op = 3'd1; operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst done", {31'b0, done}, 32'd0);
        chk("async rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        run_op(3'd7, 32'hDEADBEEF, 32'h00001234, ref_model(3'd7, 32'hDEADBEEF, 32'h00001234), "post reset REMU");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
